// File: rtl/gpio_pkg.sv
// Shared constants for the GPIO/PWM bank: register byte offsets and PWM limits.
package gpio_pkg;
  localparam logic [7:0] ADDR_DIR      = 8'h00;
  localparam logic [7:0] ADDR_OUT      = 8'h04;
  localparam logic [7:0] ADDR_IN       = 8'h08;
  localparam logic [7:0] ADDR_PWM_EN   = 8'h0C;
  localparam logic [7:0] ADDR_RISE_EN  = 8'h10;
  localparam logic [7:0] ADDR_FALL_EN  = 8'h14;
  localparam logic [7:0] ADDR_IRQ_STAT = 8'h18;
  localparam logic [7:0] PERIOD_BASE   = 8'h40;
  localparam logic [7:0] DUTY_BASE     = 8'h80;
  localparam int         PWM_W_MAX     = 16;
  localparam int         PWM_CH_MAX    = 16;
endpackage

// File: rtl/pwm_channel.sv
// One PWM channel: shadow/active period and duty, free-running counter, registered compare output.
module pwm_channel
  import gpio_pkg::*;
#(
  parameter int PWM_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             period_we,
  input  logic             duty_we,
  input  logic [PWM_W-1:0] wdata,
  output logic [PWM_W-1:0] period_shadow,
  output logic [PWM_W-1:0] duty_shadow,
  output logic             pwm_out
);
  localparam logic [PWM_W-1:0] ZERO = {PWM_W{1'b0}};

  logic [PWM_W-1:0] per_sh_r, duty_sh_r, per_act_r, duty_act_r, cnt_r;
  logic             pwm_r;
  logic [PWM_W:0]   cnt_inc_s;
  logic             wrap_s;

  // A zero period counts as a wrap every cycle so the shadows can still load.
  assign cnt_inc_s = {1'b0, cnt_r} + {{PWM_W{1'b0}}, 1'b1};
  assign wrap_s    = (per_act_r == ZERO) || (cnt_inc_s == {1'b0, per_act_r});

  // Shadow registers written from the bus.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      per_sh_r  <= ZERO;
      duty_sh_r <= ZERO;
    end else begin
      if (period_we) per_sh_r <= wdata;
      if (duty_we)   duty_sh_r <= wdata;
    end
  end

  // Counter, active copies and output; actives only change at a wrap or while disabled.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_r      <= ZERO;
      per_act_r  <= ZERO;
      duty_act_r <= ZERO;
      pwm_r      <= 1'b0;
    end else if (!en) begin
      cnt_r      <= ZERO;
      per_act_r  <= per_sh_r;
      duty_act_r <= duty_sh_r;
      pwm_r      <= 1'b0;
    end else begin
      pwm_r <= (per_act_r != ZERO) && (cnt_r < duty_act_r);
      if (wrap_s) begin
        cnt_r      <= ZERO;
        per_act_r  <= per_sh_r;
        duty_act_r <= duty_sh_r;
      end else begin
        cnt_r <= cnt_inc_s[PWM_W-1:0];
      end
    end
  end

  assign period_shadow = per_sh_r;
  assign duty_shadow   = duty_sh_r;
  assign pwm_out       = pwm_r;
endmodule

// File: rtl/gpio_pwm_bank.sv
// GPIO bank with register bus, synchronised inputs, edge interrupts and PWM channels
// muxed onto the low pins.
module gpio_pwm_bank
  import gpio_pkg::*;
#(
  parameter int WIDTH   = 20,
  parameter int NUM_PWM = 4,
  parameter int PWM_W   = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             read_request_i,
  input  logic             write_request_i,
  input  logic [31:0]      address_i,
  input  logic [31:0]      write_data_i,
  output logic [31:0]      read_data_o,
  output logic             response_o,
  input  logic [WIDTH-1:0] gpio_i,
  output logic [WIDTH-1:0] gpio_o,
  output logic [WIDTH-1:0] gpio_oe_o,
  output logic             irq_o
);
  localparam logic [WIDTH-1:0] WZERO = {WIDTH{1'b0}};

  logic [WIDTH-1:0]   dir_r, out_r, rise_en_r, fall_en_r, irq_stat_r;
  logic [WIDTH-1:0]   sync1_r, sync2_r, sync3_r;
  logic [NUM_PWM-1:0] pwm_en_r;
  logic [1:0]         warm_r;
  logic               resp_r, irq_r;
  logic [31:0]        rdata_r, rdata_s;
  logic [WIDTH-1:0]   set_s, clr_s, irq_nxt_s, gpio_o_s, gpio_oe_s;
  logic [7:0]         addr_s;
  logic [3:0]         ch_idx_s;
  logic               ch_ok_s, per_hit_s, duty_hit_s;
  logic               wr_acc_s, rd_acc_s, acc_s;
  logic [PWM_W-1:0]   per_sh_s  [PWM_CH_MAX];
  logic [PWM_W-1:0]   duty_sh_s [PWM_CH_MAX];
  logic [PWM_CH_MAX-1:0] pwm_out_s;
  logic               unused_s;

  assign addr_s     = address_i[7:0];
  assign ch_idx_s   = addr_s[5:2];
  assign ch_ok_s    = ({1'b0, ch_idx_s} < 5'(NUM_PWM)) && (addr_s[1:0] == 2'b00);
  assign per_hit_s  = ch_ok_s && (addr_s[7:6] == PERIOD_BASE[7:6]);
  assign duty_hit_s = ch_ok_s && (addr_s[7:6] == DUTY_BASE[7:6]);
  // Requests are only taken while no response is showing; a write masks a simultaneous read.
  assign acc_s      = !resp_r && (read_request_i || write_request_i);
  assign wr_acc_s   = !resp_r && write_request_i;
  assign rd_acc_s   = !resp_r && read_request_i && !write_request_i;
  assign unused_s   = ^{address_i[31:8], write_data_i, pwm_out_s};

  for (genvar n = 0; n < PWM_CH_MAX; n++) begin : g_ch
    if (n < NUM_PWM) begin : g_on
      pwm_channel #(.PWM_W(PWM_W)) u_pwm (
        .clk           (clk),
        .rst_n         (rst_n),
        .en            (pwm_en_r[n]),
        .period_we     (wr_acc_s && per_hit_s && (ch_idx_s == 4'(n))),
        .duty_we       (wr_acc_s && duty_hit_s && (ch_idx_s == 4'(n))),
        .wdata         (write_data_i[PWM_W-1:0]),
        .period_shadow (per_sh_s[n]),
        .duty_shadow   (duty_sh_s[n]),
        .pwm_out       (pwm_out_s[n])
      );
    end else begin : g_off
      assign per_sh_s[n]  = {PWM_W{1'b0}};
      assign duty_sh_s[n] = {PWM_W{1'b0}};
      assign pwm_out_s[n] = 1'b0;
    end
  end

  // Read data multiplexer.
  always_comb begin
    rdata_s = 32'h0;
    case (addr_s)
      ADDR_DIR:      rdata_s = 32'(dir_r);
      ADDR_OUT:      rdata_s = 32'(out_r);
      ADDR_IN:       rdata_s = 32'(sync2_r);
      ADDR_PWM_EN:   rdata_s = 32'(pwm_en_r);
      ADDR_RISE_EN:  rdata_s = 32'(rise_en_r);
      ADDR_FALL_EN:  rdata_s = 32'(fall_en_r);
      ADDR_IRQ_STAT: rdata_s = 32'(irq_stat_r);
      default: begin
        if (per_hit_s) begin
          rdata_s = 32'(per_sh_s[ch_idx_s]);
        end else if (duty_hit_s) begin
          rdata_s = 32'(duty_sh_s[ch_idx_s]);
        end else begin
          rdata_s = 32'h0;
        end
      end
    endcase
  end

  // Bus response pulse and registered read data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_r  <= 1'b0;
      rdata_r <= 32'h0;
    end else begin
      resp_r  <= acc_s;
      rdata_r <= rd_acc_s ? rdata_s : 32'h0;
    end
  end

  // Input synchroniser, delayed copy and post-reset edge blanking counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= WZERO;
      sync2_r <= WZERO;
      sync3_r <= WZERO;
      warm_r  <= 2'd0;
    end else begin
      sync1_r <= gpio_i;
      sync2_r <= sync1_r;
      sync3_r <= sync2_r;
      warm_r  <= (warm_r == 2'd3) ? 2'd3 : warm_r + 2'd1;
    end
  end

  // Edge sets win over a same-cycle write-1-to-clear.
  always_comb begin
    set_s = WZERO;
    clr_s = WZERO;
    if (warm_r == 2'd3) begin
      set_s = (sync2_r & ~sync3_r & rise_en_r) | (~sync2_r & sync3_r & fall_en_r);
    end else begin
      set_s = WZERO;
    end
    if (wr_acc_s && (addr_s == ADDR_IRQ_STAT)) begin
      clr_s = write_data_i[WIDTH-1:0];
    end else begin
      clr_s = WZERO;
    end
    irq_nxt_s = (irq_stat_r & ~clr_s) | set_s;
  end

  // Control registers and interrupt status.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dir_r      <= WZERO;
      out_r      <= WZERO;
      pwm_en_r   <= {NUM_PWM{1'b0}};
      rise_en_r  <= WZERO;
      fall_en_r  <= WZERO;
      irq_stat_r <= WZERO;
      irq_r      <= 1'b0;
    end else begin
      irq_stat_r <= irq_nxt_s;
      irq_r      <= |irq_nxt_s;
      if (wr_acc_s) begin
        case (addr_s)
          ADDR_DIR:     dir_r     <= write_data_i[WIDTH-1:0];
          ADDR_OUT:     out_r     <= write_data_i[WIDTH-1:0];
          ADDR_PWM_EN:  pwm_en_r  <= write_data_i[NUM_PWM-1:0];
          ADDR_RISE_EN: rise_en_r <= write_data_i[WIDTH-1:0];
          ADDR_FALL_EN: fall_en_r <= write_data_i[WIDTH-1:0];
          default: ;
        endcase
      end
    end
  end

  // Pin mux: an enabled PWM channel owns its pin and always drives it.
  always_comb begin
    gpio_o_s  = out_r;
    gpio_oe_s = dir_r;
    for (int i = 0; i < NUM_PWM; i++) begin
      if (pwm_en_r[i]) begin
        gpio_o_s[i]  = pwm_out_s[i];
        gpio_oe_s[i] = 1'b1;
      end else begin
        gpio_o_s[i]  = out_r[i];
        gpio_oe_s[i] = dir_r[i];
      end
    end
  end

  assign gpio_o      = gpio_o_s;
  assign gpio_oe_o   = gpio_oe_s;
  assign irq_o       = irq_r;
  assign response_o  = resp_r;
  assign read_data_o = rdata_r;
endmodule

// File: tb/tb_gpio_pwm_bank.sv
// Directed self-checking bench for gpio_pwm_bank: bus, pin mux, PWM waveforms, interrupts, reset.
module tb_gpio_pwm_bank;
  localparam int WIDTH   = 20;
  localparam int NUM_PWM = 4;
  localparam int PWM_W   = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             read_request_i = 1'b0;
  logic             write_request_i = 1'b0;
  logic [31:0]      address_i = 32'h0;
  logic [31:0]      write_data_i = 32'h0;
  logic [31:0]      read_data_o;
  logic             response_o;
  logic [WIDTH-1:0] gpio_i = {WIDTH{1'b0}};
  logic [WIDTH-1:0] gpio_o;
  logic [WIDTH-1:0] gpio_oe_o;
  logic             irq_o;

  int n_cmp = 0;
  int n_bad = 0;

  gpio_pwm_bank #(.WIDTH(WIDTH), .NUM_PWM(NUM_PWM), .PWM_W(PWM_W)) dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .read_request_i  (read_request_i),
    .write_request_i (write_request_i),
    .address_i       (address_i),
    .write_data_i    (write_data_i),
    .read_data_o     (read_data_o),
    .response_o      (response_o),
    .gpio_i          (gpio_i),
    .gpio_o          (gpio_o),
    .gpio_oe_o       (gpio_oe_o),
    .irq_o           (irq_o)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  task automatic bus_write(input logic [31:0] a, input logic [31:0] d);
    @(negedge clk);
    write_request_i = 1'b1;
    address_i       = a;
    write_data_i    = d;
    @(negedge clk);
    write_request_i = 1'b0;
    @(negedge clk);
  endtask

  task automatic bus_read(input logic [31:0] a, output logic [31:0] d, output logic r);
    @(negedge clk);
    read_request_i = 1'b1;
    address_i      = a;
    @(negedge clk);
    read_request_i = 1'b0;
    d = read_data_o;
    r = response_o;
    @(negedge clk);
  endtask

  // Returns at the first negedge where the pin goes from low to high.
  task automatic wait_rise(input int pin, output logic ok);
    logic prev;
    ok   = 1'b0;
    prev = gpio_o[pin];
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (!prev && gpio_o[pin]) begin
        ok = 1'b1;
        return;
      end
      prev = gpio_o[pin];
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] rd;
    logic        rs, ok, hi_all, lo_any, seen;
    logic [23:0] vec, exp_vec;

    repeat (2) @(negedge clk);
    check_eq("rst_gpio_o", 32'(gpio_o), 32'h0);
    check_eq("rst_gpio_oe", 32'(gpio_oe_o), 32'h0);
    check_eq("rst_resp_irq_rdata", {read_data_o[29:0], response_o, irq_o}, 32'h0);
    rst_n = 1'b1;
    repeat (4) @(negedge clk);

    // Bus round trip on DIR with explicit pulse-length checks.
    write_request_i = 1'b1; address_i = 32'h00; write_data_i = 32'h000F0;
    @(negedge clk);
    write_request_i = 1'b0;
    check_eq("dir_resp_high", 32'(response_o), 32'h1);
    @(negedge clk);
    check_eq("dir_resp_low", 32'(response_o), 32'h0);
    check_eq("dir_oe", 32'(gpio_oe_o), 32'h000F0);
    bus_read(32'h00, rd, rs);
    check_eq("dir_read", rd, 32'h000000F0);
    check_eq("dir_read_resp", 32'(rs), 32'h1);
    check_eq("rdata_idle", read_data_o, 32'h0);

    bus_write(32'h04, 32'hFFF000A0);
    check_eq("out_pins", 32'(gpio_o), 32'h000A0);
    bus_read(32'h04, rd, rs);
    check_eq("out_unused_bits", rd, 32'h000000A0);

    // A request held through the response cycle is ignored there.
    @(negedge clk);
    read_request_i = 1'b1; address_i = 32'h00;
    @(negedge clk);
    check_eq("held_resp1", 32'(response_o), 32'h1);
    @(negedge clk);
    read_request_i = 1'b0;
    check_eq("held_ignored", {read_data_o[30:0], response_o}, 32'h0);
    @(negedge clk);

    // Channel index beyond NUM_PWM is unmapped.
    bus_write(32'h54, 32'h1234);
    bus_read(32'h54, rd, rs);
    check_eq("period5_read", rd, 32'h0);

    // PWM channel 1: period 10, duty 3.
    bus_write(32'h44, 32'd10);
    bus_write(32'h84, 32'd3);
    bus_write(32'h0C, 32'h2);
    check_eq("pwm1_oe", 32'(gpio_oe_o[1]), 32'h1);
    wait_rise(1, ok);
    check_eq("pwm1_rise_timeout", 32'(ok), 32'h1);
    vec = 24'h0; exp_vec = 24'h0;
    for (int k = 0; k < 20; k++) begin
      if (k > 0) @(negedge clk);
      vec[k]     = gpio_o[1];
      exp_vec[k] = ((k % 10) < 3);
    end
    check_eq("pwm1_wave", 32'(vec), 32'(exp_vec));
    bus_read(32'h44, rd, rs);
    check_eq("period1_read", rd, 32'd10);

    // Channel 0: period 8 duty 4, then duty 6 written mid-period.
    bus_write(32'h40, 32'd8);
    bus_write(32'h80, 32'd4);
    bus_write(32'h0C, 32'h3);
    wait_rise(0, ok);
    check_eq("pwm0_rise_timeout", 32'(ok), 32'h1);
    vec = 24'h0; exp_vec = 24'h0;
    for (int k = 0; k < 24; k++) begin
      if (k > 0) @(negedge clk);
      vec[k]     = gpio_o[0];
      exp_vec[k] = (k < 8) ? (k < 4) : ((k % 8) < 6);
      if (k == 1) begin
        write_request_i = 1'b1; address_i = 32'h80; write_data_i = 32'd6;
      end else if (k == 2) begin
        write_request_i = 1'b0;
      end
    end
    check_eq("pwm0_shadow_wave", 32'(vec), 32'(exp_vec));
    bus_read(32'h80, rd, rs);
    check_eq("duty0_read", rd, 32'd6);

    // Corners: duty above period on ch2, zero period on ch3.
    bus_write(32'h48, 32'd10);
    bus_write(32'h88, 32'd12);
    bus_write(32'h8C, 32'd5);
    bus_write(32'h0C, 32'hF);
    repeat (3) @(negedge clk);
    hi_all = 1'b1; lo_any = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      hi_all &= gpio_o[2];
      lo_any |= gpio_o[3];
    end
    check_eq("duty_gt_period_high", 32'(hi_all), 32'h1);
    check_eq("period0_low", 32'(lo_any), 32'h0);
    write_request_i = 1'b1; address_i = 32'h0C; write_data_i = 32'hB;
    @(negedge clk);
    write_request_i = 1'b0;
    check_eq("disable_low", {30'h0, gpio_oe_o[2], gpio_o[2]}, 32'h0);
    @(negedge clk);
    bus_write(32'h0C, 32'h0);
    check_eq("pwm_off_pins", 32'(gpio_o), 32'h000A0);

    // Simultaneous read and write: write only, zero read data.
    @(negedge clk);
    read_request_i = 1'b1; write_request_i = 1'b1; address_i = 32'h04; write_data_i = 32'h55;
    @(negedge clk);
    read_request_i = 1'b0; write_request_i = 1'b0;
    check_eq("rw_both", {read_data_o[30:0], response_o}, 32'h1);
    @(negedge clk);
    check_eq("rw_both_wrote", 32'(gpio_o), 32'h00055);

    // Rising-edge interrupt.
    bus_write(32'h10, 32'h4);
    gpio_i[2] = 1'b1;
    repeat (3) @(negedge clk);
    check_eq("irq_rise", 32'(irq_o), 32'h1);
    bus_read(32'h18, rd, rs);
    check_eq("irq_stat", rd, 32'h4);
    bus_read(32'h08, rd, rs);
    check_eq("in_reg", rd, 32'h4);
    bus_write(32'h18, 32'h4);
    check_eq("irq_w1c", 32'(irq_o), 32'h0);
    gpio_i[2] = 1'b0;
    repeat (4) @(negedge clk);
    gpio_i[2] = 1'b1;
    repeat (4) @(negedge clk);
    gpio_i[2] = 1'b0;
    repeat (4) @(negedge clk);
    // New edge reaches IRQ_STAT on the third posedge, same edge as the clear.
    gpio_i[2] = 1'b1;
    repeat (2) @(negedge clk);
    write_request_i = 1'b1; address_i = 32'h18; write_data_i = 32'h4;
    @(negedge clk);
    write_request_i = 1'b0;
    @(negedge clk);
    check_eq("irq_set_wins", 32'(irq_o), 32'h1);
    bus_read(32'h18, rd, rs);
    check_eq("irq_stat_set_wins", rd, 32'h4);

    // Reset in the middle of a read.
    @(negedge clk);
    read_request_i = 1'b1; address_i = 32'h00;
    @(posedge clk);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("rst_async_bus", {read_data_o[30:0], response_o}, 32'h0);
    check_eq("rst_async_pins", {gpio_o[15:0], gpio_oe_o[14:0], irq_o}, 32'h0);
    read_request_i = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    repeat (4) begin
      @(negedge clk);
      seen |= response_o;
    end
    check_eq("no_resp_after_rst", 32'(seen), 32'h0);
    bus_read(32'h00, rd, rs);
    check_eq("dir_after_rst", rd, 32'h0);

    bus_read(32'h3C, rd, rs);
    check_eq("unmapped_data", rd, 32'h0);
    check_eq("unmapped_resp", 32'(rs), 32'h1);
    check_eq("unmapped_resp_len", 32'(response_o), 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule

// File: doc/gpio_pwm_bank.md
GPIO_PWM_BANK -- requirements
Module: gpio_pwm_bank

Interface
REQ-001 Parameter WIDTH, default 20, number of GPIO pins (1..32).
REQ-002 Parameter NUM_PWM, default 4, number of PWM channels mapped onto pins 0..NUM_PWM-1 (1..16, at most WIDTH).
REQ-003 Parameter PWM_W, default 16, PWM counter, period and duty width (1..16).
REQ-004 clk  in  1  single clock, rising edge.
REQ-005 rst_n  in  1  asynchronous active-low reset.
REQ-006 read_request_i  in  1  bus read request.
REQ-007 write_request_i  in  1  bus write request.
REQ-008 address_i  in  32  byte address; bits [7:0] decoded.
REQ-009 write_data_i  in  32  write data.
REQ-010 read_data_o  out  32  read data, valid only while response_o is high.
REQ-011 response_o  out  1  one-cycle completion pulse.
REQ-012 gpio_i  in  WIDTH  asynchronous pin inputs.
REQ-013 gpio_o  out  WIDTH  pin output values.
REQ-014 gpio_oe_o  out  WIDTH  pin output enables, 1 = drive; tri-state buffers sit outside this block.
REQ-015 irq_o  out  1  level interrupt.

Function
REQ-016 Register map, byte offsets:
- 0x00 DIR, RW.
- 0x04 OUT, RW.
- 0x08 IN, RO: synchronised pin values.
- 0x0C PWM_EN, RW, bits [NUM_PWM-1:0].
- 0x10 RISE_EN, RW.
- 0x14 FALL_EN, RW.
- 0x18 IRQ_STAT, read returns status; write-1-to-clear.
- 0x40+4*n PERIOD[n], RW.
- 0x80+4*n DUTY[n], RW.
REQ-017 Request acceptance: a request is accepted only in a cycle where response_o is low; a request is ignored while response_o is high.
REQ-018 Response timing: response_o rises exactly 1 cycle after an accepted request and stays high for exactly 1 cycle.
REQ-019 Read data: read_data_o carries the addressed value during the response cycle and is 0 in all other cycles.
REQ-020 Unused register bits read as 0.
REQ-021 Unmapped addresses and channel index n >= NUM_PWM: writes are ignored, reads return 0, and response_o still pulses.
REQ-022 If read_request_i and write_request_i are both high, the block performs the write only and returns read_data_o = 0.
REQ-023 Input path: each gpio_i bit passes through a 2-flop synchroniser; IN reflects the synchroniser output.
REQ-024 Edge detection compares the synchronised value with its 1-cycle-delayed copy; a rising or falling edge sets IRQ_STAT[i] when the matching RISE_EN[i] or FALL_EN[i] bit is 1.
REQ-025 If an edge set and a W1C clear hit the same IRQ_STAT bit in the same cycle, the set wins.
REQ-026 irq_o = OR of IRQ_STAT, driven from registers with no combinational path from the bus.
REQ-027 Pin mux for pin i < NUM_PWM with PWM_EN[i] = 1: gpio_o[i] = pwm_out[i] and gpio_oe_o[i] = 1.
REQ-028 All other pins: gpio_o = OUT and gpio_oe_o = DIR.
REQ-029 PWM counter: each channel has a counter 0..P-1, where P is the active period; the counter wraps to 0 after P-1.
REQ-030 PWM output: pwm_out = (counter < active duty).
REQ-031 PWM corner cases:
- P = 0: counter held at 0, output low.
- duty >= P: output constantly high.
- duty = 0: output constantly low.
REQ-032 Shadow registers: PERIOD and DUTY writes land in shadow registers. The active copies load from the shadows at a counter wrap (counter = P-1) or in any cycle where the channel is disabled, so there are no truncated or glitched pulses.
REQ-033 Disabling a channel (PWM_EN[n]: 1 to 0) clears its counter and pwm_out on the next cycle.
REQ-034 Re-enabling a channel starts its counter from 0.
REQ-035 Reads of PERIOD and DUTY return the shadow value.

Reset
REQ-036 While rst_n is low, asynchronously and regardless of clk:
- DIR, OUT, PWM_EN, RISE_EN, FALL_EN, IRQ_STAT, synchronisers, counters, and active and shadow PERIOD/DUTY all become 0.
- gpio_o = 0, gpio_oe_o = 0, irq_o = 0, response_o = 0, read_data_o = 0.
REQ-037 A request in flight when reset asserts is dropped, and no response is produced after reset releases.
REQ-038 Edge detection produces no edges in the first 3 cycles after reset release.

Structure
REQ-039 Package gpio_pkg holds the register offset constants, the PERIOD/DUTY base offsets, and the maximum PWM_W.
REQ-040 One sub-module, pwm_channel, per channel, generated NUM_PWM times. It holds the counter, the shadow and active registers, and the compare logic.
REQ-041 All other logic resides in gpio_pwm_bank.

Verification
REQ-042 Bus round trip: write DIR = 0x000F0 -> the next-cycle response pulse lasts 1 cycle, gpio_oe_o = 0x000F0, and a read of 0x00 returns 0x000000F0.
REQ-043 PWM waveform: PERIOD[1] = 10, DUTY[1] = 3, PWM_EN = 0x2 -> gpio_o[1] is high 3 cycles and low 7 cycles repeatedly, and gpio_oe_o[1] = 1 regardless of DIR.
REQ-044 Shadow update: with channel 0 running at period 8 and duty 4, write DUTY[0] = 6 mid-period -> the current period completes with 4 high cycles, and the next period has 6 high cycles.
REQ-045 PWM corners: duty 12 with period 10 -> constant high; period 0 -> constant low; disable mid-high -> low within 1 cycle.
REQ-046 Interrupt: RISE_EN = 0x4, gpio_i[2] rises 0 to 1 -> IRQ_STAT = 0x4 and irq_o high within 3 cycles. A W1C of 0x4 in the same cycle as a new rising edge leaves the bit set.
REQ-047 Reset and unmapped access: assert rst_n low mid-read -> all outputs 0 immediately and no response afterwards; a read of 0x3C returns 0 with a 1-cycle response.
